diff_reg_streamer: RTL and testbench

//  Parametrised successor to the per-cycle register-dump difftest hook. Snapshots the

---
 rtl/diff_pkg.sv | 19 +
 rtl/diff_lowest_set.sv | 20 ++
 rtl/diff_reg_streamer.sv | 135 +++++++++++++
 tb/tb_diff_reg_streamer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/diff_pkg.sv
// Shared types and defaults for the register-diff difftest streamer.
package diff_pkg;

  localparam int unsigned DIFF_XLEN    = 64;
  localparam int unsigned DIFF_NREGS   = 32;
  localparam int unsigned DIFF_PRIV_ID = DIFF_NREGS;
  localparam int unsigned DIFF_IDW     = $clog2(DIFF_NREGS + 1);

  typedef enum logic {
    IDLE,
    STREAM
  } diff_state_e;

  typedef struct packed {
    logic [DIFF_IDW-1:0]  id;
    logic [DIFF_XLEN-1:0] val;
  } diff_rec_t;

endpackage

// File: rtl/diff_lowest_set.sv
// Combinational priority encoder: index of the lowest set bit plus an any-set flag.
module diff_lowest_set #(
  parameter  int unsigned W  = 33,
  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    idx_o = '0;
    any_o = |vec_i;
    // Scan downwards so the lowest set bit is the last assignment.
    for (int unsigned i = W; i > 0; i--) begin
      if (vec_i[i-1]) idx_o = IW'(i - 1);
    end
  end

endmodule

// File: rtl/diff_reg_streamer.sv
// Snapshots the register file and privilege on commit and streams only the
// entries that changed as (id, value) records over a valid/ready port.
module diff_reg_streamer
  import diff_pkg::*;
#(
  parameter int unsigned XLEN      = DIFF_XLEN,
  parameter int unsigned NREGS     = DIFF_NREGS,
  parameter int unsigned PRIVW     = 2,
  parameter bit          SKIP_R0   = 1'b1,
  parameter bit          FULL_SYNC = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       commit_valid,
  input  logic [NREGS*XLEN-1:0]      regs_data,
  input  logic [PRIVW-1:0]           priv,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(NREGS+1)-1:0] out_id,
  output logic [XLEN-1:0]            out_val,
  output logic                       busy,
  output logic                       sync_done
);

  localparam int unsigned NV  = NREGS + 1;
  localparam int unsigned IDW = $clog2(NREGS + 1);

  logic [NREGS*XLEN-1:0] shadow_q, shadow_d;
  logic [PRIVW-1:0]      priv_q, priv_d;
  logic [NV-1:0]         dirty_q, dirty_d;
  logic                  first_q, first_d;
  logic                  out_valid_q, out_valid_d;
  logic [IDW-1:0]        out_id_q, out_id_d;
  logic [XLEN-1:0]       out_val_q, out_val_d;
  logic                  sync_done_q, sync_done_d;
  diff_state_e           state_q, state_d;

  logic [NV-1:0]   set_mask;
  logic [NV-1:0]   clr_mask;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;
  logic [XLEN-1:0] pick_val;
  logic            load;

  diff_lowest_set #(
    .W (NV)
  ) u_pick (
    .vec_i (dirty_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    set_mask = '0;
    if (commit_valid) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        set_mask[i] = first_q || (regs_data[i*XLEN +: XLEN] != shadow_q[i*XLEN +: XLEN]);
      end
      set_mask[NREGS] = first_q || (priv != priv_q);
      if (SKIP_R0) set_mask[0] = 1'b0;
    end
  end

  // Output values come from the pre-commit shadow, so a same-cycle commit
  // is only seen by a later load.
  always_comb begin
    pick_val = XLEN'(priv_q);
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (pick_idx == IDW'(i)) pick_val = shadow_q[i*XLEN +: XLEN];
    end
  end

  always_comb begin
    load        = !out_valid_q || out_ready;
    clr_mask    = '0;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_val_d   = out_val_q;
    if (load) begin
      out_valid_d = pick_any;
      if (pick_any) begin
        out_id_d           = pick_idx;
        out_val_d          = pick_val;
        clr_mask[pick_idx] = 1'b1;
      end
    end
    // Set after clear: a register re-committed while being loaded is re-emitted.
    dirty_d  = (dirty_q & ~clr_mask) | set_mask;
    shadow_d = commit_valid ? regs_data : shadow_q;
    priv_d   = commit_valid ? priv : priv_q;
    first_d  = first_q && !commit_valid;

    state_d     = state_q;
    sync_done_d = 1'b0;
    if (state_q == IDLE) begin
      if (|set_mask) state_d = STREAM;
    end else begin
      if (out_valid_q && out_ready && !pick_any && !(|set_mask)) begin
        state_d     = IDLE;
        sync_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_q    <= '0;
      priv_q      <= '0;
      dirty_q     <= '0;
      first_q     <= FULL_SYNC;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_val_q   <= '0;
      sync_done_q <= 1'b0;
      state_q     <= IDLE;
    end else begin
      shadow_q    <= shadow_d;
      priv_q      <= priv_d;
      dirty_q     <= dirty_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_val_q   <= out_val_d;
      sync_done_q <= sync_done_d;
      state_q     <= state_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_val   = out_val_q;
  assign busy      = (state_q == STREAM);
  assign sync_done = sync_done_q;

endmodule

// File: tb/tb_diff_reg_streamer.sv
// Randomised and directed bench for diff_reg_streamer against a pending-set model.
module tb_diff_reg_streamer;
  import diff_pkg::*;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned NREGS = 32;
  localparam int unsigned IDW   = 6;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic                  commit_valid = 1'b0;
  logic                  out_ready = 1'b0;
  logic [1:0]            priv = 2'd0;
  logic [XLEN-1:0]       regs [NREGS];
  logic [NREGS*XLEN-1:0] regs_data;
  logic                  out_valid, busy, sync_done;
  logic [IDW-1:0]        out_id;
  logic [XLEN-1:0]       out_val;

  int n_checks = 0;
  int n_fail   = 0;
  diff_rec_t log_q[$];

  diff_reg_streamer #(
    .XLEN      (XLEN),
    .NREGS     (NREGS),
    .PRIVW     (2),
    .SKIP_R0   (1'b1),
    .FULL_SYNC (1'b1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .commit_valid (commit_valid),
    .regs_data    (regs_data),
    .priv         (priv),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_id       (out_id),
    .out_val      (out_val),
    .busy         (busy),
    .sync_done    (sync_done)
  );

  always #5 clock = ~clock;

  always_comb begin
    for (int i = 0; i < NREGS; i++) regs_data[i*XLEN +: XLEN] = regs[i];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a set of pending register ids, a shadow copy and a one-record output slot.
  logic [XLEN-1:0] m_shadow [NREGS];
  logic [1:0]      m_priv = 2'd0;
  bit              m_pend [NREGS+1];
  bit              m_first = 1'b1;
  bit              m_ov = 1'b0;
  int              m_id = 0;
  logic [XLEN-1:0] m_val = '0;
  bit              m_busy = 1'b0;
  bit              m_prev_busy = 1'b0;
  bit              m_sync = 1'b0;

  initial begin
    for (int i = 0; i < NREGS; i++) m_shadow[i] = '0;
    for (int i = 0; i <= NREGS; i++) m_pend[i] = 1'b0;
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        for (int i = 0; i < NREGS; i++) m_shadow[i] = '0;
        for (int i = 0; i <= NREGS; i++) m_pend[i] = 1'b0;
        m_priv = 2'd0; m_first = 1'b1; m_ov = 1'b0; m_id = 0; m_val = '0;
        m_busy = 1'b0; m_prev_busy = 1'b0; m_sync = 1'b0;
      end else begin
        if (!m_ov || out_ready) begin
          int k;
          k = -1;
          for (int i = 0; i <= NREGS; i++) if (m_pend[i] && k < 0) k = i;
          if (k >= 0) begin
            m_ov  = 1'b1;
            m_id  = k;
            m_val = (k == NREGS) ? 64'(m_priv) : m_shadow[k];
            m_pend[k] = 1'b0;
          end else begin
            m_ov = 1'b0;
          end
        end
        if (commit_valid) begin
          for (int i = 1; i < NREGS; i++) if (m_first || regs[i] != m_shadow[i]) m_pend[i] = 1'b1;
          if (m_first || priv != m_priv) m_pend[NREGS] = 1'b1;
          for (int i = 0; i < NREGS; i++) m_shadow[i] = regs[i];
          m_priv  = priv;
          m_first = 1'b0;
        end
        m_busy = m_ov;
        for (int i = 0; i <= NREGS; i++) if (m_pend[i]) m_busy = 1'b1;
        m_sync = m_prev_busy && !m_busy;
        m_prev_busy = m_busy;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("sync_done", 64'(sync_done), 64'(m_sync));
      if (m_ov) begin
        chk("out_id", 64'(out_id), 64'(m_id));
        chk("out_val", out_val, m_val);
      end
      if (out_valid && out_ready && !reset) begin
        diff_rec_t r;
        r.id  = out_id;
        r.val = out_val;
        log_q.push_back(r);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_commit();
    commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
  endtask

  task automatic wait_sync(input string name, input int budget);
    bit got;
    got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      tick();
      if (sync_done) got = 1'b1;
    end
    chk(name, 64'(got), 64'd1);
  endtask

  initial begin
    int base;
    int zeros;
    logic [IDW-1:0]  hold_id;
    logic [XLEN-1:0] hold_val;

    for (int i = 0; i < NREGS; i++) regs[i] = '0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sync_done", 64'(sync_done), 64'd0);
    chk("rst_out_id", 64'(out_id), 64'd0);
    chk("rst_out_val", out_val, 64'd0);

    // Full sync after reset
    base = log_q.size();
    regs[0] = 64'hBAD;
    for (int i = 1; i < NREGS; i++) regs[i] = 64'(32'h10 + i);
    priv = 2'd3;
    out_ready = 1'b1;
    do_commit();
    chk("t1_lat_snapshot_valid", 64'(out_valid), 64'd0);
    chk("t1_lat_snapshot_busy", 64'(busy), 64'd1);
    tick();
    chk("t1_lat_load_valid", 64'(out_valid), 64'd1);
    chk("t1_first_id", 64'(out_id), 64'd1);
    chk("t1_first_val", out_val, 64'h11);
    wait_sync("t1_sync_timeout", 100);
    chk("t1_count", 64'(log_q.size() - base), 64'd32);
    chk("t1_rec0_id", 64'(log_q[base].id), 64'd1);
    chk("t1_rec30_val", log_q[base+30].val, 64'h2F);
    chk("t1_last_id", 64'(log_q[base+31].id), 64'd32);
    chk("t1_last_val", log_q[base+31].val, 64'd3);
    zeros = 0;
    for (int j = base; j < log_q.size(); j++) if (log_q[j].id == '0) zeros++;
    chk("t1_r0_seen", 64'(zeros), 64'd0);

    // Single change, then an identical recommit
    base = log_q.size();
    regs[5] = 64'hDEAD;
    do_commit();
    chk("t2_snapshot_valid", 64'(out_valid), 64'd0);
    tick();
    chk("t2_valid", 64'(out_valid), 64'd1);
    chk("t2_id", 64'(out_id), 64'd5);
    chk("t2_val", out_val, 64'hDEAD);
    wait_sync("t2_sync_timeout", 20);
    chk("t2_count", 64'(log_q.size() - base), 64'd1);
    do_commit();
    repeat (5) begin
      tick();
      chk("t2_quiet_valid", 64'(out_valid), 64'd0);
      chk("t2_quiet_busy", 64'(busy), 64'd0);
    end

    // Back-pressure holds the record stable
    base = log_q.size();
    out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) regs[i] = regs[i] + 64'h100;
    do_commit();
    tick();
    hold_id  = out_id;
    hold_val = out_val;
    chk("t3_hold_id_lit", 64'(hold_id), 64'd1);
    chk("t3_hold_val_lit", hold_val, 64'h111);
    repeat (10) begin
      tick();
      chk("t3_hold_valid", 64'(out_valid), 64'd1);
      chk("t3_hold_id", 64'(out_id), 64'(hold_id));
      chk("t3_hold_val", out_val, hold_val);
    end
    out_ready = 1'b1;
    wait_sync("t3_sync_timeout", 40);
    chk("t3_count", 64'(log_q.size() - base), 64'd10);
    for (int j = 0; j < 10; j++) chk("t3_order", 64'(log_q[base+j].id), 64'(j + 1));

    // Coalescing while the record is still unloaded
    base = log_q.size();
    out_ready = 1'b0;
    regs[3] = 64'h333;
    regs[7] = 64'd1;
    do_commit();
    regs[7] = 64'd2;
    do_commit();
    out_ready = 1'b1;
    wait_sync("t4a_sync_timeout", 20);
    chk("t4a_count", 64'(log_q.size() - base), 64'd2);
    chk("t4a_id", 64'(log_q[base+1].id), 64'd7);
    chk("t4a_val", log_q[base+1].val, 64'd2);

    // Re-commit in the same cycle the first value is loaded
    base = log_q.size();
    regs[7] = 64'd3;
    commit_valid = 1'b1;
    tick();
    regs[7] = 64'd4;
    tick();
    commit_valid = 1'b0;
    wait_sync("t4b_sync_timeout", 20);
    chk("t4b_count", 64'(log_q.size() - base), 64'd2);
    chk("t4b_val0", log_q[base].val, 64'd3);
    chk("t4b_val1", log_q[base+1].val, 64'd4);

    // Asynchronous reset mid-stream, then a fresh full sync
    out_ready = 1'b0;
    for (int i = 11; i <= 20; i++) regs[i] = regs[i] ^ 64'hFF;
    do_commit();
    repeat (3) tick();
    chk("t5_busy_before", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_valid", 64'(out_valid), 64'd0);
    chk("t5_async_busy", 64'(busy), 64'd0);
    tick();
    reset = 1'b0;
    base = log_q.size();
    out_ready = 1'b1;
    do_commit();
    wait_sync("t5_sync_timeout", 100);
    chk("t5_full_count", 64'(log_q.size() - base), 64'd32);

    // Privilege-only change
    base = log_q.size();
    priv = 2'd1;
    do_commit();
    wait_sync("t6_sync_timeout", 20);
    chk("t6_count", 64'(log_q.size() - base), 64'd1);
    chk("t6_id", 64'(log_q[base].id), 64'd32);
    chk("t6_val", log_q[base].val, 64'd1);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      commit_valid = ($urandom_range(0, 9) < 3);
      if (commit_valid) begin
        int n;
        n = $urandom_range(0, 3);
        for (int m = 0; m < n; m++) begin
          if ($urandom_range(0, 1) == 0)
            regs[$urandom_range(0, NREGS-1)] = 64'($urandom_range(0, 3));
          else
            regs[$urandom_range(0, NREGS-1)] = {$urandom, $urandom};
        end
        if ($urandom_range(0, 7) == 0) priv = 2'($urandom_range(0, 3));
      end
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    commit_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 100 && busy; c++) tick();
    chk("rand_drain_busy", 64'(busy), 64'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
